// File: rtl/oam_dma.sv
// OAM DMA controller: transparent CPU<->iram pass-through while idle. A write to
// REG_ADDR takes the bus and copies LEN bytes from {page,8'h00} to DEST_BASE.
module oam_dma #(
   parameter logic [15:0] REG_ADDR  = 16'hFF46,
   parameter logic [15:0] DEST_BASE = 16'hFE00,
   parameter int unsigned LEN       = 160
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_adr,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] mem_adr,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        dma_active
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      READ  = 2'd2,
      WRITE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SEL_PASS  = 2'd0,
      SEL_REG   = 2'd1,
      SEL_BLOCK = 2'd2
   } rd_sel_t;

   localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

   state_t     state_q, state_d;
   logic [7:0] src_page_q, src_page_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] data_q, data_d;
   rd_sel_t    rd_sel_q, rd_sel_d;

   logic reg_hit;
   logic reg_wr;
   logic last_byte;

   assign reg_hit   = (cpu_adr == REG_ADDR);
   assign reg_wr    = cpu_wr && reg_hit;
   assign last_byte = (idx_q == LAST_IDX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         src_page_q <= 8'h00;
         idx_q      <= 8'h00;
         data_q     <= 8'h00;
         rd_sel_q   <= SEL_PASS;
      end else begin
         state_q    <= state_d;
         src_page_q <= src_page_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         rd_sel_q   <= rd_sel_d;
      end
   end

   // A register write restarts the copy from any state, overriding completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = IDLE;
         START:   state_d = READ;
         READ:    state_d = WRITE;
         WRITE:   state_d = last_byte ? IDLE : READ;
         default: state_d = IDLE;
      endcase
      if (reg_wr) begin
         state_d = START;
      end
   end

   always_comb begin
      src_page_d = src_page_q;
      idx_d      = idx_q;
      data_d     = data_q;
      if (state_q == WRITE) begin
         data_d = mem_rdata;
         if (!last_byte) begin
            idx_d = idx_q + 8'd1;
         end
      end
      if (reg_wr) begin
         src_page_d = cpu_wdata;
         idx_d      = 8'h00;
      end
   end

   // Read-return select is registered so it lines up with the iram's 1-cycle latency.
   always_comb begin
      if (reg_hit) begin
         rd_sel_d = SEL_REG;
      end else if (state_q != IDLE) begin
         rd_sel_d = SEL_BLOCK;
      end else begin
         rd_sel_d = SEL_PASS;
      end
   end

   always_comb begin
      case (rd_sel_q)
         SEL_REG:   cpu_rdata = src_page_q;
         SEL_BLOCK: cpu_rdata = 8'hFF;
         default:   cpu_rdata = mem_rdata;
      endcase
   end

   // The byte addressed in READ comes back during WRITE and is forwarded straight out.
   always_comb begin
      mem_adr    = cpu_adr;
      mem_wdata  = cpu_wdata;
      mem_wr     = 1'b0;
      dma_active = 1'b1;
      case (state_q)
         IDLE: begin
            mem_wr     = cpu_wr && !reg_hit;
            dma_active = 1'b0;
         end
         START: begin
            mem_adr = cpu_adr;
         end
         READ: begin
            mem_adr = {src_page_q, idx_q};
         end
         WRITE: begin
            mem_adr   = DEST_BASE + {8'h00, idx_q};
            mem_wdata = mem_rdata;
            mem_wr    = 1'b1;
         end
         default: begin
            dma_active = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a 1-cycle-latency iram model behind the DMA.
module tb_oam_dma;

   localparam logic [15:0] REG_ADDR = 16'hFF46;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_adr;
   logic        cpu_wr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_adr;
   logic        mem_wr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        dma_active;

   logic [7:0] mem [0:65535];
   int reg_fwd_cnt = 0;
   int tests_run   = 0;
   int failed      = 0;

   always #5 clk = ~clk;

   oam_dma dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_adr    (cpu_adr),
      .cpu_wr     (cpu_wr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .mem_adr    (mem_adr),
      .mem_wr     (mem_wr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .dma_active (dma_active)
   );

   always @(posedge clk) begin
      if (mem_wr) mem[mem_adr] <= mem_wdata;
      mem_rdata <= mem[mem_adr];
      if (mem_wr && mem_adr == REG_ADDR) reg_fwd_cnt <= reg_fwd_cnt + 1;
   end

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      cpu_adr = a; cpu_wdata = d; cpu_wr = 1'b1;
      @(negedge clk);
      cpu_wr = 1'b0;
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
      @(negedge clk);
      cpu_adr = a; cpu_wr = 1'b0;
      @(negedge clk);
      d = cpu_rdata;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (dma_active && n < 2000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      logic [7:0] d;
      rst = 1'b0; cpu_wr = 1'b0; cpu_adr = 16'h1234; cpu_wdata = 8'h00;
      repeat (3) @(negedge clk);
      tests_run++;
      if (dma_active !== 1'b0) begin failed++; $display("FAIL reset_active: got %b want 0", dma_active); end
      tests_run++;
      if (mem_wr !== 1'b0) begin failed++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
      tests_run++;
      if (mem_adr !== 16'h1234) begin failed++; $display("FAIL reset_passthru_adr: got %h want 1234", mem_adr); end
      rst = 1'b1;
      cpu_read(REG_ADDR, d);
      tests_run++;
      if (d !== 8'h00) begin failed++; $display("FAIL reset_reg: got %h want 00", d); end
   endtask

   task automatic test_pass_through;
      logic [7:0] d;
      int n, snap;
      cpu_write(16'hC123, 8'hA5);
      cpu_read(16'hC123, d);
      tests_run++;
      if (d !== 8'hA5) begin failed++; $display("FAIL pass_rd: got %h want a5", d); end
      snap = reg_fwd_cnt;
      @(negedge clk);
      cpu_adr = REG_ADDR; cpu_wdata = 8'hC0; cpu_wr = 1'b1;
      #1;
      tests_run++;
      if (mem_wr !== 1'b0) begin failed++; $display("FAIL pass_reg_masked: mem_wr %b want 0", mem_wr); end
      @(negedge clk);
      cpu_wr = 1'b0;
      tests_run++;
      if (dma_active !== 1'b1) begin failed++; $display("FAIL pass_reg_start: active %b want 1", dma_active); end
      wait_idle(n);
      tests_run++;
      if (reg_fwd_cnt !== snap) begin failed++; $display("FAIL pass_reg_fwd: writes %0d want %0d", reg_fwd_cnt, snap); end
   endtask

   task automatic test_basic;
      int n, bad;
      for (int i = 0; i < 160; i++) cpu_write(16'hC000 + 16'(i), 8'(i) ^ 8'h5A);
      for (int i = 0; i < 160; i++) cpu_write(16'hFE00 + 16'(i), 8'h00);
      cpu_write(16'hFEA0, 8'h77);
      cpu_write(REG_ADDR, 8'hC0);
      wait_idle(n);
      tests_run++;
      if (n !== 321) begin failed++; $display("FAIL basic_len: active cycles %0d want 321", n); end
      bad = 0;
      for (int i = 0; i < 160; i++) begin
         tests_run++;
         if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) begin
            failed++; bad++;
            if (bad < 5) $display("FAIL basic_oam[%0d]: got %h want %h", i, mem[16'hFE00 + 16'(i)], 8'(i) ^ 8'h5A);
         end
      end
      tests_run++;
      if (mem[16'hFEA0] !== 8'h77) begin failed++; $display("FAIL basic_fea0: got %h want 77", mem[16'hFEA0]); end
   endtask

   task automatic test_reg_readback;
      logic [7:0] d;
      int n;
      cpu_write(REG_ADDR, 8'h81);
      cpu_read(REG_ADDR, d);
      tests_run++;
      if (dma_active !== 1'b1) begin failed++; $display("FAIL rb_active: active %b want 1", dma_active); end
      tests_run++;
      if (d !== 8'h81) begin failed++; $display("FAIL rb_active_val: got %h want 81", d); end
      wait_idle(n);
      cpu_read(REG_ADDR, d);
      tests_run++;
      if (d !== 8'h81) begin failed++; $display("FAIL rb_idle_val: got %h want 81", d); end
   endtask

   task automatic test_isolation;
      logic [7:0] d;
      int n;
      cpu_write(REG_ADDR, 8'hC0);
      cpu_write(16'hC010, 8'h33);
      cpu_read(16'hC000, d);
      tests_run++;
      if (d !== 8'hFF) begin failed++; $display("FAIL iso_rd_blocked: got %h want ff", d); end
      wait_idle(n);
      tests_run++;
      if (mem[16'hC010] !== 8'h4A) begin failed++; $display("FAIL iso_wr_dropped: got %h want 4a", mem[16'hC010]); end
      tests_run++;
      if (mem[16'hFE10] !== 8'h4A) begin failed++; $display("FAIL iso_oam10: got %h want 4a", mem[16'hFE10]); end
      cpu_read(16'hC000, d);
      tests_run++;
      if (d !== 8'h5A) begin failed++; $display("FAIL iso_rd_after: got %h want 5a", d); end
   endtask

   task automatic test_restart;
      logic [7:0] d;
      int n, drops, bad;
      for (int i = 0; i < 160; i++) cpu_write(16'hD000 + 16'(i), 8'(i) ^ 8'hA3);
      cpu_write(REG_ADDR, 8'hC0);
      drops = 0;
      repeat (100) begin
         @(negedge clk);
         if (!dma_active) drops++;
      end
      cpu_write(REG_ADDR, 8'hD0);
      if (!dma_active) drops++;
      tests_run++;
      if (drops !== 0) begin failed++; $display("FAIL restart_continuous: idle samples %0d want 0", drops); end
      wait_idle(n);
      tests_run++;
      if (n !== 321) begin failed++; $display("FAIL restart_len: active cycles %0d want 321", n); end
      cpu_read(REG_ADDR, d);
      tests_run++;
      if (d !== 8'hD0) begin failed++; $display("FAIL restart_page: got %h want d0", d); end
      bad = 0;
      for (int i = 0; i < 160; i++) begin
         tests_run++;
         if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'hA3)) begin
            failed++; bad++;
            if (bad < 5) $display("FAIL restart_oam[%0d]: got %h want %h", i, mem[16'hFE00 + 16'(i)], 8'(i) ^ 8'hA3);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] d;
      int bad;
      for (int i = 16'h50; i < 16'hA0; i++) cpu_write(16'hFE00 + 16'(i), 8'hEE);
      cpu_write(REG_ADDR, 8'hC0);
      repeat (161) @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (dma_active !== 1'b0) begin failed++; $display("FAIL rstmid_active: got %b want 0", dma_active); end
      tests_run++;
      if (mem_wr !== 1'b0) begin failed++; $display("FAIL rstmid_mem_wr: got %b want 0", mem_wr); end
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      tests_run++;
      if (mem[16'hFE4F] !== (8'h4F ^ 8'h5A)) begin failed++; $display("FAIL rstmid_fe4f: got %h want %h", mem[16'hFE4F], 8'h4F ^ 8'h5A); end
      bad = 0;
      for (int i = 16'h50; i < 16'hA0; i++) begin
         tests_run++;
         if (mem[16'hFE00 + 16'(i)] !== 8'hEE) begin
            failed++; bad++;
            if (bad < 5) $display("FAIL rstmid_untouched[%0h]: got %h want ee", i, mem[16'hFE00 + 16'(i)]);
         end
      end
      cpu_read(REG_ADDR, d);
      tests_run++;
      if (d !== 8'h00) begin failed++; $display("FAIL rstmid_reg: got %h want 00", d); end
      cpu_write(16'hC200, 8'h3C);
      cpu_read(16'hC200, d);
      tests_run++;
      if (d !== 8'h3C) begin failed++; $display("FAIL rstmid_passthru: got %h want 3c", d); end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_pass_through;
      test_basic;
      test_reg_readback;
      test_isolation;
      test_restart;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
